// File: rtl/fetch_ctrl_if.sv
// Fetch controller bus bundle: redirect/stall control, I-cache port, instruction-queue port.
interface fetch_ctrl_if;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        icache_read;
  logic [31:0] icache_address;
  logic        icache_resp;
  logic [31:0] icache_rdata;
  logic        inst_q_full;
  logic        inst_q_issue;
  logic [31:0] inst_q_datain;
  logic [31:0] inst_q_pc;
  logic        inst_q_flush;
  logic [31:0] fetch_pc;

  // Fetch controller side
  modport master (
    input  stall, redirect_valid, redirect_pc, icache_resp, icache_rdata, inst_q_full,
    output icache_read, icache_address, inst_q_issue, inst_q_datain, inst_q_pc,
           inst_q_flush, fetch_pc
  );

  // Environment side (cache, queue, branch unit)
  modport slave (
    output stall, redirect_valid, redirect_pc, icache_resp, icache_rdata, inst_q_full,
    input  icache_read, icache_address, inst_q_issue, inst_q_datain, inst_q_pc,
           inst_q_flush, fetch_pc
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, issues hold-until-resp I-cache reads and
// pushes returned instructions into the instruction queue; redirects flush the
// queue and discard any in-flight response.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
  input  logic         clk,
  input  logic         rst,
  fetch_ctrl_if.master bus
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t            state;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   req_addr;
  logic [XLEN-1:0]   pend_pc;
  logic [XLEN-1:0]   hold_data;
  logic [XLEN-1:0]   hold_pc;
  logic [XLEN-1:0]   pc_inc;
  logic              push_fetch_c;
  logic              push_hold_c;

  // Sequential PC; wraps modulo 2^32
  assign pc_inc = pc + XLEN'(4);

  // A push happens on an accepted response or when held data drains; a redirect always wins
  assign push_fetch_c = (state == FETCH) && bus.icache_resp && !bus.inst_q_full && !bus.redirect_valid;
  assign push_hold_c  = (state == HOLD) && !bus.inst_q_full && !bus.redirect_valid;

  // Output decode from registered state
  assign bus.icache_read    = (state == FETCH) || (state == DISCARD);
  assign bus.icache_address = req_addr;
  assign bus.inst_q_flush   = bus.redirect_valid;
  assign bus.inst_q_issue   = push_fetch_c || push_hold_c;
  assign bus.inst_q_datain  = (state == HOLD) ? hold_data : bus.icache_rdata;
  assign bus.inst_q_pc      = (state == HOLD) ? hold_pc : req_addr;
  assign bus.fetch_pc       = pc;

  // Fetch state machine and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      req_addr  <= RESET_PC;
      pend_pc   <= RESET_PC;
      hold_data <= '0;
      hold_pc   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.redirect_valid) begin
            pc <= bus.redirect_pc;
          end else if (!bus.stall && !bus.inst_q_full) begin
            req_addr <= pc;
            state    <= FETCH;
          end
        end
        FETCH: begin
          if (bus.redirect_valid) begin
            if (bus.icache_resp) begin
              pc    <= bus.redirect_pc;
              state <= IDLE;
            end else begin
              // Keep the read asserted until the cache answers, then drop it
              pend_pc <= bus.redirect_pc;
              state   <= DISCARD;
            end
          end else if (bus.icache_resp) begin
            pc <= pc_inc;
            if (bus.inst_q_full) begin
              hold_data <= bus.icache_rdata;
              hold_pc   <= req_addr;
              state     <= HOLD;
            end else if (!bus.stall) begin
              req_addr <= pc_inc;
            end else begin
              state <= IDLE;
            end
          end
        end
        DISCARD: begin
          if (bus.icache_resp) begin
            pc    <= bus.redirect_valid ? bus.redirect_pc : pend_pc;
            state <= IDLE;
          end else if (bus.redirect_valid) begin
            pend_pc <= bus.redirect_pc;
          end
        end
        HOLD: begin
          if (bus.redirect_valid || !bus.inst_q_full) begin
            if (bus.redirect_valid) begin
              pc <= bus.redirect_pc;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed cycle table, async reset check,
// then randomized traffic against a transaction-level reference model.
module tb_fetch_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   errors = 0;

  fetch_ctrl_if bus ();

  fetch_ctrl #(.RESET_PC(32'h0000_0060)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        full;
    logic        redir;
    logic [31:0] rpc;
    logic        resp;
    logic [31:0] rdata;
    logic        e_read;
    logic [31:0] e_addr;
    logic        e_issue;
    logic [31:0] e_din;
    logic [31:0] e_qpc;
    logic [31:0] e_fpc;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [31:0] addr;
  } push_t;

  vec_t  tbl[$];
  push_t exp_q[$];

  // Reference model state
  logic [31:0] next_req;
  logic        poisoned;

  // Per-cycle samples
  logic        rd, rsp_b, st_b, fu_b, rv_b;
  logic [31:0] ad;
  int          qn;
  push_t       ent;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic st, input logic fu, input logic rv, input logic [31:0] rpc,
                              input logic rs, input logic [31:0] rdat, input logic er,
                              input logic [31:0] ea, input logic ei, input logic [31:0] ed,
                              input logic [31:0] eq, input logic [31:0] ef);
    vec_t v;
    v.stall = st; v.full = fu; v.redir = rv; v.rpc = rpc; v.resp = rs; v.rdata = rdat;
    v.e_read = er; v.e_addr = ea; v.e_issue = ei; v.e_din = ed; v.e_qpc = eq; v.e_fpc = ef;
    return v;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  task automatic drive(input logic st, input logic fu, input logic rv, input logic [31:0] rpc,
                       input logic rs, input logic [31:0] rdat);
    bus.stall = st; bus.inst_q_full = fu; bus.redirect_valid = rv;
    bus.redirect_pc = rpc; bus.icache_resp = rs; bus.icache_rdata = rdat;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    // stall, full, redir, rpc, resp, rdata | read, addr, issue, din, qpc, fetch_pc
    tbl.push_back(mk(0,0,0,32'h0,        0,32'h0,        0,32'h60,      0,32'h0,        32'h0,        32'h60));
    tbl.push_back(mk(0,0,0,32'h0,        1,32'h1111_0000,1,32'h60,      1,32'h1111_0000,32'h60,       32'h60));
    tbl.push_back(mk(0,0,0,32'h0,        1,32'h2222_0000,1,32'h64,      1,32'h2222_0000,32'h64,       32'h64));
    tbl.push_back(mk(0,1,0,32'h0,        1,32'hDEAD_BEEF,1,32'h68,      0,32'h0,        32'h0,        32'h68));
    tbl.push_back(mk(0,1,0,32'h0,        0,32'h0,        0,32'h68,      0,32'h0,        32'h0,        32'h6C));
    tbl.push_back(mk(0,0,0,32'h0,        0,32'h0,        0,32'h68,      1,32'hDEAD_BEEF,32'h68,       32'h6C));
    tbl.push_back(mk(0,0,0,32'h0,        0,32'h0,        0,32'h68,      0,32'h0,        32'h0,        32'h6C));
    tbl.push_back(mk(0,0,0,32'h0,        0,32'h0,        1,32'h6C,      0,32'h0,        32'h0,        32'h6C));
    tbl.push_back(mk(0,0,1,32'h200,      0,32'h0,        1,32'h6C,      0,32'h0,        32'h0,        32'h6C));
    tbl.push_back(mk(0,0,0,32'h0,        0,32'h0,        1,32'h6C,      0,32'h0,        32'h0,        32'h6C));
    tbl.push_back(mk(0,0,0,32'h0,        1,32'hBAD0_0001,1,32'h6C,      0,32'h0,        32'h0,        32'h6C));
    tbl.push_back(mk(0,0,0,32'h0,        0,32'h0,        0,32'h6C,      0,32'h0,        32'h0,        32'h200));
    tbl.push_back(mk(0,0,0,32'h0,        0,32'h0,        1,32'h200,     0,32'h0,        32'h0,        32'h200));
    tbl.push_back(mk(0,0,1,32'h400,      1,32'hBAD0_0002,1,32'h200,     0,32'h0,        32'h0,        32'h200));
    tbl.push_back(mk(0,0,0,32'h0,        0,32'h0,        0,32'h200,     0,32'h0,        32'h0,        32'h400));
    tbl.push_back(mk(1,0,0,32'h0,        0,32'h0,        1,32'h400,     0,32'h0,        32'h0,        32'h400));
    tbl.push_back(mk(1,0,0,32'h0,        1,32'h3333_0000,1,32'h400,     1,32'h3333_0000,32'h400,      32'h400));
    tbl.push_back(mk(1,0,0,32'h0,        0,32'h0,        0,32'h400,     0,32'h0,        32'h0,        32'h404));
    tbl.push_back(mk(1,0,0,32'h0,        0,32'h0,        0,32'h400,     0,32'h0,        32'h0,        32'h404));
    tbl.push_back(mk(0,0,0,32'h0,        0,32'h0,        0,32'h400,     0,32'h0,        32'h0,        32'h404));
    tbl.push_back(mk(0,0,0,32'h0,        0,32'h0,        1,32'h404,     0,32'h0,        32'h0,        32'h404));
    tbl.push_back(mk(1,0,0,32'h0,        1,32'h4444_0000,1,32'h404,     1,32'h4444_0000,32'h404,      32'h404));
    tbl.push_back(mk(0,1,0,32'h0,        0,32'h0,        0,32'h404,     0,32'h0,        32'h0,        32'h408));
    tbl.push_back(mk(0,1,0,32'h0,        0,32'h0,        0,32'h404,     0,32'h0,        32'h0,        32'h408));
    tbl.push_back(mk(0,1,1,32'hFFFF_FFFC,0,32'h0,        0,32'h404,     0,32'h0,        32'h0,        32'h408));
    tbl.push_back(mk(0,0,0,32'h0,        0,32'h0,        0,32'h404,     0,32'h0,        32'h0,        32'hFFFF_FFFC));
    tbl.push_back(mk(0,0,0,32'h0,        1,32'h5555_0000,1,32'hFFFF_FFFC,1,32'h5555_0000,32'hFFFF_FFFC,32'hFFFF_FFFC));
    tbl.push_back(mk(0,0,0,32'h0,        0,32'h0,        1,32'h0,       0,32'h0,        32'h0,        32'h0));
    tbl.push_back(mk(0,0,1,32'h800,      0,32'h0,        1,32'h0,       0,32'h0,        32'h0,        32'h0));
    tbl.push_back(mk(0,0,1,32'h900,      0,32'h0,        1,32'h0,       0,32'h0,        32'h0,        32'h0));
    tbl.push_back(mk(0,0,0,32'h0,        1,32'hBAD0_0003,1,32'h0,       0,32'h0,        32'h0,        32'h0));
    tbl.push_back(mk(1,0,0,32'h0,        0,32'h0,        0,32'h0,       0,32'h0,        32'h0,        32'h900));

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_read",   32'(bus.icache_read), 32'd0);
    chk("rst_issue",  32'(bus.inst_q_issue), 32'd0);
    chk("rst_flush",  32'(bus.inst_q_flush), 32'd0);
    chk("rst_addr",   bus.icache_address, 32'h60);
    chk("rst_fpc",    bus.fetch_pc, 32'h60);
    @(negedge clk);
    rst = 1'b1;

    // Directed cycle table
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].stall, tbl[i].full, tbl[i].redir, tbl[i].rpc, tbl[i].resp, tbl[i].rdata);
      #1;
      chk($sformatf("v%0d_read", i),  32'(bus.icache_read), 32'(tbl[i].e_read));
      chk($sformatf("v%0d_addr", i),  bus.icache_address, tbl[i].e_addr);
      chk($sformatf("v%0d_issue", i), 32'(bus.inst_q_issue), 32'(tbl[i].e_issue));
      chk($sformatf("v%0d_flush", i), 32'(bus.inst_q_flush), 32'(tbl[i].redir));
      chk($sformatf("v%0d_fpc", i),   bus.fetch_pc, tbl[i].e_fpc);
      if (tbl[i].e_issue) begin
        chk($sformatf("v%0d_din", i), bus.inst_q_datain, tbl[i].e_din);
        chk($sformatf("v%0d_qpc", i), bus.inst_q_pc, tbl[i].e_qpc);
      end
      @(negedge clk);
    end

    // Asynchronous reset in the middle of a read
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    chk("async_pre_read", 32'(bus.icache_read), 32'd1);
    chk("async_pre_addr", bus.icache_address, 32'h900);
    #2;
    rst = 1'b0;
    #1;
    chk("async_read", 32'(bus.icache_read), 32'd0);
    chk("async_fpc",  bus.fetch_pc, 32'h60);
    chk("async_addr", bus.icache_address, 32'h60);

    // Randomized traffic against the reference model
    next_req = 32'h60;
    poisoned = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      logic st, fu, rv, rs;
      logic [31:0] rpc;
      st  = ($urandom_range(0, 3) == 0);
      fu  = (c < 2980) && ($urandom_range(0, 2) == 0);
      rv  = (c < 2980) && ($urandom_range(0, 11) == 0);
      rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : {$urandom(), 2'b00};
      rs  = bus.icache_read && ($urandom_range(0, 2) == 0);
      drive(st, fu, rv, rpc, rs, mem_word(bus.icache_address));
      #1;
      rd = bus.icache_read;
      ad = bus.icache_address;
      qn = exp_q.size();
      chk("r_flush", 32'(bus.inst_q_flush), 32'(rv));
      if (rd && rs && !poisoned && !rv) begin
        ent.data = mem_word(ad);
        ent.addr = ad;
        exp_q.push_back(ent);
        next_req = ad + 32'd4;
      end
      if (bus.inst_q_issue) begin
        chk("r_issue_not_full", 32'(fu), 32'd0);
        chk("r_issue_not_flush", 32'(rv), 32'd0);
        if (exp_q.size() == 0) begin
          chk("r_issue_unexpected", 32'd1, 32'd0);
        end else begin
          ent = exp_q.pop_front();
          chk("r_din", bus.inst_q_datain, ent.data);
          chk("r_qpc", bus.inst_q_pc, ent.addr);
        end
      end
      if (rv) begin
        exp_q.delete();
        next_req = rpc;
        if (rd && !rs) poisoned = 1'b1;
      end
      if (rd && rs) poisoned = rv ? 1'b0 : 1'b0;
      if (rd && rs && rv) next_req = rpc;
      rsp_b = rs; st_b = st; fu_b = fu; rv_b = rv;
      @(posedge clk);
      #1;
      if (rd && !rsp_b) begin
        chk("r_read_held", 32'(bus.icache_read), 32'd1);
        chk("r_addr_stable", bus.icache_address, ad);
      end else if (bus.icache_read) begin
        chk("r_launch_allowed", {29'd0, st_b, fu_b, rv_b}, 32'd0);
        chk("r_launch_addr", bus.icache_address, next_req);
      end else if (!rd && qn == 0 && !st_b && !fu_b && !rv_b) begin
        chk("r_launch_missing", 32'(bus.icache_read), 32'd1);
      end
      if (!poisoned) chk("r_fetch_pc", bus.fetch_pc, next_req);
      @(negedge clk);
    end
    chk("r_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
